face_code_editor: RTL and testbench
===================================

// Module: face_code_editor
// PURPOSE
//  Upstream feeder for the 4-bit 2:1 face-feature mux. Holds two editable 4-bit
//  feature codes (code_a -> mux in1, code_b -> mux in2) and drives the mux select.
//  Button one-shots edit the active slot. A lock pulse freezes both codes and
//  alternates select at a fixed rate, so the display previews both face parts.
// PARAMETERS
//  CODE_MAX       9           highest legal code; codes wrap 0..CODE_MAX (CODE_MAX <= 15)
//  TOGGLE_CYCLES  25_000_000  clk cycles per select phase in LOCKED (1 .. 2^26-1)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-low reset
//  inc_pulse    in   1  one-cycle pulse: active code +1
//  dec_pulse    in   1  one-cycle pulse: active code -1
//  slot_pulse   in   1  one-cycle pulse: swap active slot A<->B
//  lock_pulse   in   1  one-cycle pulse: EDIT_x -> LOCKED, LOCKED -> EDIT_A
//  code_a       out  4  slot A code, to mux in1
//  code_b       out  4  slot B code, to mux in2
//  select       out  1  mux select: 0 = code_a, 1 = code_b
//  locked       out  1  high while in LOCKED
// BEHAVIOUR
//  - All outputs registered. Every input pulse takes effect at the next rising clk edge.
//  - rst low (async): state=EDIT_A, code_a=0, code_b=0, select=0, locked=0, phase ctr=0.
//  - FSM states: EDIT_A, EDIT_B, LOCKED.
//    EDIT_A : slot_pulse -> EDIT_B; lock_pulse -> LOCKED
//    EDIT_B : slot_pulse -> EDIT_A; lock_pulse -> LOCKED
//    LOCKED : lock_pulse -> EDIT_A; slot/inc/dec ignored
//  - Priority per cycle: lock_pulse > slot_pulse > inc/dec. Any edit that loses
//    priority is dropped, not deferred.
//  - Editing applies only in EDIT_A (code_a) or EDIT_B (code_b). The other code holds.
//    inc: code == CODE_MAX -> 0, else code+1.
//    dec: code == 0 -> CODE_MAX, else code-1.
//    inc and dec in the same cycle -> no change.
//  - select in EDIT_A = 0; in EDIT_B = 1 (follows the new state on the same edge).
//  - LOCKED: on entry, select=0 and the 26-bit phase ctr is cleared. The ctr counts
//    0..TOGGLE_CYCLES-1. At terminal count the ctr wraps to 0 and select toggles.
//    Each phase is exactly TOGGLE_CYCLES cycles.
//  - Leaving LOCKED: ctr cleared, select=0, codes keep their locked values.
//  - locked = 1 exactly while state == LOCKED.
//  - Codes never leave 0..CODE_MAX. Reset asserted mid-count aborts everything.
// TESTING  (bench uses CODE_MAX=9, TOGGLE_CYCLES=4)
//  1 Reset release -> code_a=0, code_b=0, select=0, locked=0. Assert rst mid-LOCKED
//    -> same values immediately, without a clk edge.
//  2 EDIT_A, 10 inc pulses -> code_a steps 1..9 then 0. One dec from 0 -> 9.
//    code_b stays 0.
//  3 slot_pulse -> select=1 next edge. 3 inc -> code_b=3, code_a unchanged.
//    slot_pulse again -> select=0.
//  4 inc+dec same cycle -> no change. slot+inc same cycle -> slot swaps, no code change.
//  5 code_a=7, code_b=3, lock_pulse -> locked=1, select=0 for 4 cycles, then 1 for 4,
//    repeating. inc/slot ignored. Codes stay 7 and 3.
//  6 lock_pulse while select=1 in LOCKED -> EDIT_A, select=0, locked=0, codes 7 and 3.
//    Next inc -> code_a=8.

Source files
------------

// File: rtl/face_code_editor.sv
// Editable two-slot feature-code source for the 4-bit 2:1 face mux.
// Edits the active slot on button pulses; a lock pulse freezes codes and alternates the select.
module face_code_editor #(
  parameter int unsigned CODE_MAX      = 9,
  parameter int unsigned TOGGLE_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_pulse,
  input  logic       dec_pulse,
  input  logic       slot_pulse,
  input  logic       lock_pulse,
  output logic [3:0] code_a,
  output logic [3:0] code_b,
  output logic       select,
  output logic       locked
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned CTR_W  = 26;
  localparam logic [CODE_W-1:0] CODE_TOP = CODE_W'(CODE_MAX);
  localparam logic [CTR_W-1:0]  CTR_TC   = CTR_W'(TOGGLE_CYCLES - 1);

  typedef enum logic [1:0] {
    EDIT_A = 2'd0,
    EDIT_B = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CODE_W-1:0] r_code_a;
  logic [CODE_W-1:0] r_code_b;
  logic [CODE_W-1:0] w_code_a_nxt;
  logic [CODE_W-1:0] w_code_b_nxt;
  logic [CODE_W-1:0] w_edit_in;
  logic [CODE_W-1:0] w_edit_out;
  logic              r_select;
  logic              w_select_nxt;
  logic              r_locked;
  logic [CTR_W-1:0]  r_ctr;
  logic [CTR_W-1:0]  w_ctr_nxt;

  // Next state, wrapped code edit and lock-phase timing; lock beats slot beats inc/dec.
  always_comb begin
    w_state_nxt  = r_state;
    w_code_a_nxt = r_code_a;
    w_code_b_nxt = r_code_b;
    w_select_nxt = r_select;
    w_ctr_nxt    = r_ctr;
    w_edit_in    = (r_state == EDIT_B) ? r_code_b : r_code_a;
    w_edit_out   = w_edit_in;

    if (inc_pulse && !dec_pulse) begin
      w_edit_out = (w_edit_in == CODE_TOP) ? '0 : w_edit_in + CODE_W'(1);
    end else if (dec_pulse && !inc_pulse) begin
      w_edit_out = (w_edit_in == '0) ? CODE_TOP : w_edit_in - CODE_W'(1);
    end

    case (r_state)
      EDIT_A, EDIT_B: begin
        if (lock_pulse) begin
          w_state_nxt  = LOCKED;
          w_select_nxt = 1'b0;
          w_ctr_nxt    = '0;
        end else if (slot_pulse) begin
          w_state_nxt  = (r_state == EDIT_A) ? EDIT_B : EDIT_A;
          w_select_nxt = (r_state == EDIT_A);
        end else if (r_state == EDIT_A) begin
          w_code_a_nxt = w_edit_out;
        end else begin
          w_code_b_nxt = w_edit_out;
        end
      end
      LOCKED: begin
        if (lock_pulse) begin
          w_state_nxt  = EDIT_A;
          w_select_nxt = 1'b0;
          w_ctr_nxt    = '0;
        end else if (r_ctr == CTR_TC) begin
          w_ctr_nxt    = '0;
          w_select_nxt = ~r_select;
        end else begin
          w_ctr_nxt    = r_ctr + CTR_W'(1);
        end
      end
      default: begin
        w_state_nxt  = EDIT_A;
        w_select_nxt = 1'b0;
        w_ctr_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= EDIT_A;
      r_code_a <= '0;
      r_code_b <= '0;
      r_select <= 1'b0;
      r_locked <= 1'b0;
      r_ctr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_code_a <= w_code_a_nxt;
      r_code_b <= w_code_b_nxt;
      r_select <= w_select_nxt;
      r_locked <= (w_state_nxt == LOCKED);
      r_ctr    <= w_ctr_nxt;
    end
  end

  assign code_a = r_code_a;
  assign code_b = r_code_b;
  assign select = r_select;
  assign locked = r_locked;

endmodule

// File: tb/tb_face_code_editor.sv
// Self-checking bench for face_code_editor: directed scenarios plus random pulses
// compared each cycle against a behavioural model of the editor.
module tb_face_code_editor;

  localparam int CMAX = 9;
  localparam int TC   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc_pulse = 1'b0;
  logic       dec_pulse = 1'b0;
  logic       slot_pulse = 1'b0;
  logic       lock_pulse = 1'b0;
  logic [3:0] code_a;
  logic [3:0] code_b;
  logic       select;
  logic       locked;

  int n_checks = 0;
  int n_err    = 0;

  // Model: mode 0 = editing A, 1 = editing B, 2 = locked; m_lk = cycles since lock entry.
  int m_mode = 0;
  int m_a    = 0;
  int m_b    = 0;
  int m_lk   = 0;

  face_code_editor #(.CODE_MAX(CMAX), .TOGGLE_CYCLES(TC)) dut (
    .clk(clk), .rst(rst),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .slot_pulse(slot_pulse), .lock_pulse(lock_pulse),
    .code_a(code_a), .code_b(code_b), .select(select), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_a = 0; m_b = 0; m_lk = 0;
    end else if (lock_pulse) begin
      if (m_mode == 2) m_mode = 0;
      else begin m_mode = 2; m_lk = 0; end
    end else if (m_mode == 2) begin
      m_lk = m_lk + 1;
    end else if (slot_pulse) begin
      m_mode = 1 - m_mode;
    end else if (inc_pulse != dec_pulse) begin
      int v;
      v = (m_mode == 0) ? m_a : m_b;
      v = inc_pulse ? (v + 1) % (CMAX + 1) : (v + CMAX) % (CMAX + 1);
      if (m_mode == 0) m_a = v; else m_b = v;
    end
  end

  function automatic int m_sel();
    if (m_mode == 1) return 1;
    if (m_mode == 2) return (m_lk / TC) % 2;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model code_a", int'(code_a), m_a);
    check("model code_b", int'(code_b), m_b);
    check("model select", int'(select), m_sel());
    check("model locked", int'(locked), (m_mode == 2) ? 1 : 0);
  endtask

  // Apply one pulse set for one edge, then compare against the model at the falling edge.
  task automatic step(input logic i, input logic d, input logic s, input logic l);
    inc_pulse = i; dec_pulse = d; slot_pulse = s; lock_pulse = l;
    @(posedge clk);
    @(negedge clk);
    inc_pulse = 1'b0; dec_pulse = 1'b0; slot_pulse = 1'b0; lock_pulse = 1'b0;
    cmp_model();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset code_a", int'(code_a), 0);
    check("reset code_b", int'(code_b), 0);
    check("reset select", int'(select), 0);
    check("reset locked", int'(locked), 0);
    cmp_model();

    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("inc code_a", int'(code_a), i % 10);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("dec wrap code_a", int'(code_a), 9);
    check("slot b untouched", int'(code_b), 0);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("slot select b", int'(select), 1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("edit code_b", int'(code_b), 3);
    check("edit b keeps a", int'(code_a), 9);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("slot select a", int'(select), 0);

    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("inc+dec no change", int'(code_a), 9);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("slot+inc select", int'(select), 1);
    check("slot+inc code_a", int'(code_a), 9);
    check("slot+inc code_b", int'(code_b), 3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("preset code_a", int'(code_a), 7);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lock locked", int'(locked), 1);
    check("lock select", int'(select), 0);
    for (int k = 1; k < 16; k++) begin
      step(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)), 1'b0);
      check("lock phase select", int'(select), (k / 4) % 2);
    end
    check("lock code_a", int'(code_a), 7);
    check("lock code_b", int'(code_b), 3);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("unlock locked", int'(locked), 0);
    check("unlock select", int'(select), 0);
    check("unlock code_a", int'(code_a), 7);
    check("unlock code_b", int'(code_b), 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("post-unlock inc", int'(code_a), 8);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async rst code_a", int'(code_a), 0);
    check("async rst code_b", int'(code_b), 0);
    check("async rst select", int'(select), 0);
    check("async rst locked", int'(locked), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp_model();

    for (int n = 0; n < 4000; n++) begin
      step(1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0),
           1'($urandom_range(3) == 0), 1'($urandom_range(19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
